pe_bus_scheduler: RTL and testbench

- Sequencer for one column of glb_PE instances sharing a single multicast BUS_IF.
- Takes a packed filter/ifmap word stream from the global buffer and steps through tags 0..NUM_COL-1.
- Per tag it configures the PEs, streams kernel_size words tagged for that PE, then pulses flush.
- Sits between the GLB read port and the bus inputs of the glb_PE chain (ID/TAG match, READY, EN, kernel_size, flush).

---
 rtl/pe_bus_scheduler.sv | 165 ++++++++++++++++
 tb/tb_pe_bus_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_bus_scheduler.sv
// pe_bus_scheduler: sequences one column of PEs that share a multicast bus.
// For each tag 0..NUM_COL-1 it configures the PEs, streams kernel_size GLB
// words onto the bus tagged for that PE, then pulses flush. The FSM is split
// into a state register, next-state logic and Moore/Mealy output logic.
module pe_bus_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int TAG_W      = $clog2(NUM_COL)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [7:0]              cfg_kernel_size,
  input  logic                    src_valid,
  input  logic [2*DATA_WIDTH-1:0] src_data,
  output logic                    src_ready,
  input  logic                    bus_ready,
  output logic                    bus_valid,
  output logic [2*DATA_WIDTH-1:0] bus_data,
  output logic [TAG_W-1:0]        bus_tag,
  output logic                    bus_en,
  output logic [7:0]              bus_kernel_size,
  output logic                    bus_flush,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_LOAD  = 3'd2,
    S_FLUSH = 3'd3,
    S_NEXT  = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(NUM_COL - 1);

  state_t           state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       ks_q, ks_d;
  logic             xfer;

  // A word moves only while loading and both sides are ready.
  assign xfer = (state_q == S_LOAD) && src_valid && bus_ready;

  // State register plus the tag, word counter and latched kernel size.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      cnt_q   <= '0;
      ks_q    <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      ks_q    <= ks_d;
    end
  end

  // Next-state logic; abort overrides the normal path in every busy state.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    ks_d    = ks_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && (cfg_kernel_size != 8'd0)) begin
          ks_d    = cfg_kernel_size;
          tag_d   = '0;
          state_d = S_CFG;
        end
      end
      S_CFG: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (xfer) begin
          cnt_d = cnt_q + 8'd1;
          // cnt_q < ks_q here, so the increment never wraps even at ks_q=255.
          if ((cnt_q + 8'd1) == ks_q) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (tag_q == LAST_TAG) begin
          tag_d   = '0;
          state_d = S_IDLE;
        end else begin
          tag_d   = tag_q + TAG_W'(1);
          state_d = S_CFG;
        end
      end
      S_ABORT: begin
        cnt_d   = '0;
        tag_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A word in flight during the abort cycle still crosses the bus, but the
    // count and tag updates are dropped; ABORT itself clears them.
    if (abort && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
      state_d = S_ABORT;
      tag_d   = tag_q;
      cnt_d   = cnt_q;
      ks_d    = ks_q;
    end
  end

  // Output decode; the LOAD datapath is a zero-latency pass-through.
  always_comb begin
    src_ready       = 1'b0;
    bus_valid       = 1'b0;
    bus_data        = '0;
    bus_tag         = tag_q;
    bus_en          = 1'b0;
    bus_kernel_size = ks_q;
    bus_flush       = 1'b0;
    busy            = (state_q != S_IDLE);
    done            = 1'b0;
    err             = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        err = start && (cfg_kernel_size == 8'd0) && !rstn;
      end
      S_CFG: begin
        bus_en = 1'b1;
      end
      S_LOAD: begin
        bus_en    = 1'b1;
        bus_valid = src_valid;
        src_ready = bus_ready;
        bus_data  = src_data;
      end
      S_FLUSH: begin
        bus_en    = 1'b1;
        bus_flush = 1'b1;
      end
      S_NEXT: begin
        bus_en = 1'b1;
        done   = (tag_q == LAST_TAG) && !abort && !rstn;
      end
      S_ABORT: begin
        bus_flush = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_pe_bus_scheduler.sv
// Scoreboard bench for pe_bus_scheduler: stimulus pushes expected bus words,
// flush pulses, done cycles and err pulses into queues; a monitor pops and
// compares whenever the DUT presents the corresponding event.
module tb_pe_bus_scheduler;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [7:0]    cfg_kernel_size;
  logic          src_valid;
  logic [2*DW-1:0] src_data;
  logic          src_ready;
  logic          bus_ready;
  logic          bus_valid;
  logic [2*DW-1:0] bus_data;
  logic [TW-1:0] bus_tag;
  logic          bus_en;
  logic [7:0]    bus_kernel_size;
  logic          bus_flush;
  logic          busy;
  logic          done;
  logic          err;

  pe_bus_scheduler #(.DATA_WIDTH(DW), .NUM_COL(NC)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_kernel_size(cfg_kernel_size),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_data(bus_data),
    .bus_tag(bus_tag), .bus_en(bus_en), .bus_kernel_size(bus_kernel_size),
    .bus_flush(bus_flush), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] src_q[$];
  logic [63:0] exp_w[$];
  logic [63:0] exp_f[$];
  int          exp_d[$];
  int          exp_e[$];

  bit mon_en  = 1'b0;
  bit src_en  = 1'b0;
  int br_mode = 0;
  int rdy_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event seen, expected none (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] mkword(input int p, input int t, input int w);
    logic [15:0] v;
    v = 16'(p * 256 + t * 16 + w);
    return {16'hF000 | v, 16'h1000 | v};
  endfunction

  task automatic push_src(input int p, input int ks);
    for (int t = 0; t < NC; t++)
      for (int w = 0; w < ks; w++)
        src_q.push_back(mkword(p, t, w));
  endtask

  task automatic exp_words(input int p, input int ks, input int nfull, input int extra);
    for (int t = 0; t < nfull; t++)
      for (int w = 0; w < ks; w++)
        exp_w.push_back(64'({2'(t), mkword(p, t, w)}));
    for (int w = 0; w < extra; w++)
      exp_w.push_back(64'({2'(nfull), mkword(p, nfull, w)}));
  endtask

  task automatic exp_flushes(input int nfull, input int abort_tag);
    for (int t = 0; t < nfull; t++) exp_f.push_back(64'({2'(t), 1'b1}));
    if (abort_tag >= 0) exp_f.push_back(64'({2'(abort_tag), 1'b0}));
  endtask

  // Drives start for one cycle; returns the cycle index in which start was high.
  task automatic start_pass(input int ks, input bit exp_done, input bit timed, output int c);
    start = 1'b1;
    cfg_kernel_size = 8'(ks);
    c = cyc;
    if (exp_done) exp_d.push_back(timed ? c + NC * (ks + 3) : -1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cycle(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("wait_cycle", 64'(cyc), 64'(n));
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < limit);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", limit);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 64'({src_ready, bus_valid, bus_en, bus_flush, busy, done, err}), 64'(0));
    chk({tag, "_bus_data"}, 64'(bus_data), 64'(0));
    chk({tag, "_bus_tag"}, 64'(bus_tag), 64'(0));
    chk({tag, "_bus_ks"}, 64'(bus_kernel_size), 64'(0));
  endtask

  // Source model: holds its head word until it is consumed.
  initial begin
    bit fire;
    src_valid = 1'b0;
    src_data  = '0;
    bus_ready = 1'b0;
    forever begin
      @(negedge clk);
      fire = src_valid && src_ready;
      @(posedge clk); #2;
      if (fire && src_q.size() > 0) void'(src_q.pop_front());
      src_valid = src_en && (src_q.size() > 0);
      src_data  = src_valid ? src_q[0] : '0;
      if (br_mode == 0)      bus_ready = 1'b1;
      else if (br_mode == 1) bus_ready = ~bus_ready;
      else                   bus_ready = 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    logic [63:0] e;
    int          d;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus_valid && bus_ready) begin
          if (exp_w.size() == 0) unexpected("bus_word");
          else begin
            e = exp_w.pop_front();
            chk("bus_word", 64'({bus_tag, bus_data}), e);
          end
        end
        if (prev_stall && bus_valid) chk("stall_hold", 64'(bus_data), 64'(prev_data));
        prev_stall = bus_valid && !bus_ready;
        prev_data  = bus_data;
        if (bus_flush) begin
          if (exp_f.size() == 0) unexpected("flush");
          else begin
            e = exp_f.pop_front();
            chk("flush_tag_en_valid", 64'({bus_tag, bus_en, bus_valid}), 64'({e[2:0], 1'b0}));
          end
        end
        if (done) begin
          if (exp_d.size() == 0) unexpected("done");
          else begin
            d = exp_d.pop_front();
            if (d >= 0) chk("done_cycle", 64'(cyc), 64'(d));
          end
        end
        if (err) begin
          if (exp_e.size() == 0) unexpected("err");
          else begin
            void'(exp_e.pop_front());
            chk("err_busy", 64'(busy), 64'(0));
          end
        end
        if (src_ready) rdy_cnt++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rstn = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_kernel_size = 8'd0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b0;
    src_en = 1'b1;
    br_mode = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Pass 1: ks=3, no stalls, timed done, 12 src_ready pulses.
    rdy_cnt = 0;
    push_src(1, 3);
    exp_words(1, 3, 4, 0);
    exp_flushes(4, -1);
    start_pass(3, 1'b1, 1'b1, c);
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("ks_latched", 64'(bus_kernel_size), 64'(3));
    wait_idle(200);
    chk("src_ready_pulses", 64'(rdy_cnt), 64'(12));

    // Pass 2: ks=3 with bus_ready toggling every cycle.
    br_mode = 1;
    push_src(2, 3);
    exp_words(2, 3, 4, 0);
    exp_flushes(4, -1);
    start_pass(3, 1'b1, 1'b0, c);
    wait_idle(200);
    br_mode = 0;
    @(posedge clk); #1;

    // Zero kernel size is rejected.
    exp_e.push_back(1);
    start_pass(0, 1'b0, 1'b0, c);
    @(negedge clk);
    chk("err_then_busy", 64'(busy), 64'(0));
    chk("err_then_en", 64'(bus_en), 64'(0));
    @(posedge clk); #1;

    // Second start while busy is ignored.
    push_src(4, 3);
    exp_words(4, 3, 4, 0);
    exp_flushes(4, -1);
    start_pass(3, 1'b1, 1'b1, c);
    wait_cycle(c + 3);
    start = 1'b1;
    cfg_kernel_size = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cycle(c + 8);
    @(negedge clk);
    chk("ks_unchanged", 64'(bus_kernel_size), 64'(3));
    wait_idle(200);

    // Abort in LOAD of tag 2 after its first word.
    push_src(5, 3);
    exp_words(5, 3, 2, 2);
    exp_flushes(2, 2);
    start_pass(3, 1'b0, 1'b0, c);
    wait_cycle(c + 15);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_flush", 64'(bus_flush), 64'(1));
    chk("abort_en", 64'(bus_en), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_idle", 64'(busy), 64'(0));
    @(posedge clk); #1;
    src_q.delete();

    // Clean ks=2 pass from tag 0 after the abort.
    push_src(6, 2);
    exp_words(6, 2, 4, 0);
    exp_flushes(4, -1);
    start_pass(2, 1'b1, 1'b1, c);
    wait_idle(200);

    // Reset in the middle of LOAD of tag 1.
    push_src(7, 3);
    exp_words(7, 3, 1, 1);
    exp_flushes(1, -1);
    start_pass(3, 1'b0, 1'b0, c);
    wait_cycle(c + 9);
    rstn = 1'b1;
    src_en = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("midpass_reset");
    @(posedge clk); #1;
    src_q.delete();
    src_en = 1'b1;
    @(posedge clk); #1;

    // Abort coincides with the final word of tag 3.
    push_src(8, 3);
    exp_words(8, 3, 3, 3);
    exp_flushes(3, 3);
    start_pass(3, 1'b0, 1'b0, c);
    wait_cycle(c + 22);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("last_abort_flush", 64'(bus_flush), 64'(1));
    chk("last_abort_en", 64'(bus_en), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("last_abort_idle", 64'({busy, done}), 64'(0));
    repeat (3) @(posedge clk);
    #1;

    chk("words_left", 64'(exp_w.size()), 64'(0));
    chk("flush_left", 64'(exp_f.size()), 64'(0));
    chk("done_left", 64'(exp_d.size()), 64'(0));
    chk("err_left", 64'(exp_e.size()), 64'(0));
    chk("src_left", 64'(src_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
